intc_request_arbiter: RTL
=========================

Name: intc_request_arbiter

Overview:
Request side of the interrupt controller. It captures the six IO interrupt lines into a pending register and resolves priority against the in-service bits. It raises intr to the CPU, and on the CPU's inta handshake it issues the one-hot load to the in-service register and presents the interrupt vector. Bits [2:0] are the fast interrupts and bits [5:3] are the normal interrupts, matching the in-service register layout.

Parameters:
VECTOR_BASE, 8'h20, vector for index 0; index i yields VECTOR_BASE+i, and VECTOR_BASE+7 is the spurious vector.
NUM_IRQ, 6, number of request lines; the design supports only 6.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
irq  in  6  raw requests; [2:0] fast, [5:3] normal; synchronous to clk
imr  in  6  mask; 1 = masked
isr_in  in  6  current in-service bits (the ISR Dout)
inta  in  1  CPU acknowledge; may be held for several cycles
intr  out  1  interrupt request to the CPU
isr_ld  out  1  one-cycle load strobe to the ISR
isr_din  out  6  one-hot grant, OR-ed into the ISR
vec_valid  out  1  one-cycle strobe; vector is valid
vector  out  8  interrupt vector
irr  out  6  pending-request register, for debug

Behaviour:
- Reset (reset=0, asynchronous): irr=0, intr=0, isr_ld=0, isr_din=0, vec_valid=0, vector=0, irq_q=0, state=IDLE.
- Capture:
  - irq_q registers irq every cycle.
  - A rising edge (irq & ~irq_q) sets the matching irr bit.
  - An irr bit clears only on a grant of that bit.
  - If a set and a grant-clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Priority:
  - eligible = irr & ~imr.
  - Rank equals bit index; index 0 is highest, so all fast requests outrank all normal requests.
  - The winner is the lowest set index of eligible, and only if it is strictly lower than the lowest set index of isr_in (isr_in=0 means any index qualifies).
  - Equal or lower priority waits until the ISR clears.
- FSM states: IDLE, REQ, ACK, HOLD.
  - IDLE: if a qualifying winner exists, go to REQ; intr goes to 1 on that same edge, one cycle after the irr bit is set.
  - REQ: intr=1. The winner is re-resolved every cycle, so a higher request arriving before inta takes over.
    - inta=1 with a valid winner w: go to ACK. On that edge isr_ld=1, isr_din=1<<w, vec_valid=1, vector=VECTOR_BASE+w, irr[w]=0, intr=0.
    - inta=1 with no valid winner (masked or withdrawn in the meantime): spurious. Go to ACK with vec_valid=1, vector=VECTOR_BASE+7, isr_ld=0, isr_din=0, irr unchanged, intr=0.
    - Winner lost with inta=0: intr=0, go to IDLE.
  - ACK: isr_ld, vec_valid and isr_din return to 0. vector holds its value until the next grant. If inta=1 go to HOLD, otherwise go to IDLE.
  - HOLD: wait for inta=0, then go to IDLE. No new intr is raised while in HOLD.
- inta received in IDLE or ACK is ignored.
- Latency: irq edge to intr is 2 cycles; inta sampled to isr_ld/vector is 1 cycle.
- Only one grant is ever outstanding; isr_din is always one-hot or zero.
- Reset during REQ, ACK or HOLD aborts immediately to reset values; no isr_ld is produced.

Optional Feature:
INTC_LEVEL_TRIG_EN.
- Defined: irr tracks irq level directly each cycle (irr <= irq_q) and the edge detector is removed. A granted source must drop its line before it can be re-requested; grant-clear applies only for the grant cycle.
- Undefined: edge-triggered capture as specified above.

Test Plan:
- Reset release, irq=6'b000100 edge -> irr=000100, intr=1 two cycles later; inta pulse -> next cycle isr_ld=1, isr_din=000100, vector=8'h22, irr=0.
- irq[4] and irq[1] rise together -> grant isr_din=000010, vector=8'h21; irq[4] stays pending and is granted on the next inta (vector=8'h24).
- isr_in=000010, irq[3] rises -> intr stays 0; irq[0] rises -> intr=1, grant vector=8'h20.
- intr high for irq[5], imr[5] set to 1 before inta -> intr drops. Alternatively, if inta and the mask land in the same cycle -> vector=8'h27, isr_ld=0, irr[5] still 1.
- inta held for 4 cycles -> exactly one isr_ld pulse; a new request is not raised until one cycle after inta falls.
- Reset asserted while in REQ -> all outputs 0 asynchronously; with INTC_LEVEL_TRIG_EN, a held irq[2] re-raises intr after reset release.

Source files
------------

// File: rtl/intc_request_arbiter.sv
// Interrupt request capture, priority resolution and INTA handshake sequencing.
// Optional build macro INTC_LEVEL_TRIG_EN: irr follows the registered irq level instead of edges.
module intc_request_arbiter #(
    parameter logic [7:0] VECTOR_BASE = 8'h20,
    parameter int         NUM_IRQ     = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic [NUM_IRQ-1:0] isr_in,
    input  logic               inta,
    output logic               intr,
    output logic               isr_ld,
    output logic [NUM_IRQ-1:0] isr_din,
    output logic               vec_valid,
    output logic [7:0]         vector,
    output logic [NUM_IRQ-1:0] irr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [2:0] NONE_IDX = 3'd7;

    // Lowest set index wins; NONE_IDX when nothing is set, so it never compares as higher priority.
    function automatic logic [2:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        logic [2:0] idx;
        idx = NONE_IDX;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[2:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t             state_r, state_s;
    logic [NUM_IRQ-1:0] irq_q_r;
    logic [NUM_IRQ-1:0] irr_r, irr_s;
    logic [NUM_IRQ-1:0] clr_s;
    logic [NUM_IRQ-1:0] eligible_s;
    logic [NUM_IRQ-1:0] onehot_s;
    logic [2:0]         win_idx_s, isr_idx_s;
    logic               win_ok_s;
    logic               intr_r, intr_s;
    logic               isr_ld_r, isr_ld_s;
    logic [NUM_IRQ-1:0] isr_din_r, isr_din_s;
    logic               vec_valid_r, vec_valid_s;
    logic [7:0]         vector_r, vector_s;

    // Priority resolution against the in-service bits.
    always_comb begin
        eligible_s = irr_r & ~imr;
        win_idx_s  = lowest_idx(eligible_s);
        isr_idx_s  = lowest_idx(isr_in);
        win_ok_s   = (win_idx_s != NONE_IDX) && (win_idx_s < isr_idx_s);
        onehot_s   = {{(NUM_IRQ-1){1'b0}}, 1'b1} << win_idx_s;
    end

    // Next-state and registered-output values for the handshake FSM.
    always_comb begin
        state_s     = state_r;
        intr_s      = 1'b0;
        isr_ld_s    = 1'b0;
        isr_din_s   = {NUM_IRQ{1'b0}};
        vec_valid_s = 1'b0;
        vector_s    = vector_r;
        clr_s       = {NUM_IRQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (win_ok_s) begin
                    state_s = REQ;
                    intr_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (inta) begin
                    state_s     = ACK;
                    vec_valid_s = 1'b1;
                    if (win_ok_s) begin
                        isr_ld_s  = 1'b1;
                        isr_din_s = onehot_s;
                        clr_s     = onehot_s;
                        vector_s  = VECTOR_BASE + {5'd0, win_idx_s};
                    end else begin
                        vector_s  = VECTOR_BASE + 8'd7;
                    end
                end else if (win_ok_s) begin
                    state_s = REQ;
                    intr_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACK: begin
                if (inta) begin
                    state_s = HOLD;
                end else begin
                    state_s = IDLE;
                end
            end
            HOLD: begin
                if (!inta) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

`ifdef INTC_LEVEL_TRIG_EN
    // Level capture: the grant clears the bit only for the grant cycle.
    always_comb begin
        irr_s = irq_q_r & ~clr_s;
    end
`else
    logic [NUM_IRQ-1:0] rise_s;

    // Edge capture: a new edge beats a simultaneous grant-clear of the same bit.
    always_comb begin
        rise_s = irq & ~irq_q_r;
        irr_s  = (irr_r & ~clr_s) | rise_s;
    end
`endif

    // State, capture and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            irq_q_r     <= {NUM_IRQ{1'b0}};
            irr_r       <= {NUM_IRQ{1'b0}};
            intr_r      <= 1'b0;
            isr_ld_r    <= 1'b0;
            isr_din_r   <= {NUM_IRQ{1'b0}};
            vec_valid_r <= 1'b0;
            vector_r    <= 8'h00;
        end else begin
            state_r     <= state_s;
            irq_q_r     <= irq;
            irr_r       <= irr_s;
            intr_r      <= intr_s;
            isr_ld_r    <= isr_ld_s;
            isr_din_r   <= isr_din_s;
            vec_valid_r <= vec_valid_s;
            vector_r    <= vector_s;
        end
    end

    assign intr      = intr_r;
    assign isr_ld    = isr_ld_r;
    assign isr_din   = isr_din_r;
    assign vec_valid = vec_valid_r;
    assign vector    = vector_r;
    assign irr       = irr_r;

endmodule
